roce_tx_meta_arb: RTL
=====================

ROCE_TX_META_ARB -- requirements
Module: roce_tx_meta_arb

Interface
REQ-001 SHALL have parameter N_CHAN, default 4, number of role-side tx-meta channels (1..16).
REQ-002 SHALL have parameter META_W, default 160, width of one tx-meta word.
REQ-003 SHALL have parameter CNT_W, default 32, width of each per-channel statistics counter.
REQ-004 SHALL have port net_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port net_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_meta_valid  input  N_CHAN  per-channel request valid.
REQ-007 SHALL have port s_meta_ready  output  N_CHAN  per-channel accept.
REQ-008 SHALL have port s_meta_data  input  N_CHAN*META_W  channel i at bits [i*META_W +: META_W].
REQ-009 SHALL have port chan_en  input  N_CHAN  per-channel enable mask; 0 = never granted.
REQ-010 SHALL have port m_meta_valid  output  1  merged-stream valid toward the RoCE core.
REQ-011 SHALL have port m_meta_ready  input  1  merged-stream ready.
REQ-012 SHALL have port m_meta_data  output  META_W  granted meta word.
REQ-013 SHALL have port m_meta_chan  output  max(1,$clog2(N_CHAN))  index of channel that sourced m_meta_data.
REQ-014 SHALL have port stat_issued  output  N_CHAN*CNT_W  per-channel words delivered (present only when ROCE_ARB_STATS_EN is defined).

Function
REQ-015 SHALL hold one output register (data, chan, valid); two states: EMPTY (m_meta_valid=0), FULL (m_meta_valid=1).
REQ-016 SHALL define load = (EMPTY or m_meta_ready) and at least one channel with s_meta_valid & chan_en.
REQ-017 SHALL select grant combinationally by round-robin: first requesting enabled channel searching from last_grant+1 upward, wrapping N_CHAN-1 -> 0.
REQ-018 SHALL drive s_meta_ready[i] = load & grant[i]; at most one bit high per cycle; never high for a disabled channel.
REQ-019 SHALL, on load, capture the granted data/index at the clock edge, set valid, and update last_grant to the granted index; latency input handshake -> m_meta_valid is 1 cycle.
REQ-020 SHALL transition EMPTY->FULL on load; FULL->EMPTY on m_meta_ready without load; FULL->FULL on m_meta_ready with load (back-to-back, 1 word/cycle) or on !m_meta_ready.
REQ-021 SHALL keep m_meta_data and m_meta_chan stable while m_meta_valid=1 and m_meta_ready=0.
REQ-022 SHALL leave an already-registered word unaffected when its channel's chan_en deasserts; only future grants are masked.
REQ-023 SHALL, with N_CHAN=1, reduce to a single-entry pipeline register with m_meta_chan tied 0.
REQ-024 SHALL grant a channel whose valid is held continuously within N_CHAN loads (starvation bound).

Reset
REQ-025 SHALL, when net_rst is high at an edge, set m_meta_valid=0, m_meta_data=0, m_meta_chan=0, last_grant=N_CHAN-1 (channel 0 highest priority next), all stat_issued counters=0.
REQ-026 SHALL drive s_meta_ready=0 during any cycle net_rst is high; a word held mid-transfer is discarded.

Configuration
REQ-027 SHALL, with ROCE_ARB_STATS_EN defined, increment stat_issued[i] by 1 on each m_meta_valid & m_meta_ready with m_meta_chan=i, saturating at all-ones (no wrap).
REQ-028 SHALL, without ROCE_ARB_STATS_EN, omit the stat_issued port and counters; arbitration behaviour identical.

Verification
REQ-029 SHALL cover: N_CHAN=4, all chan_en=1, all valid continuously, m_meta_ready=1 -> m_meta_chan sequence 0,1,2,3,0,... one word per cycle after first.
REQ-030 SHALL cover: only channel 2 valid, m_meta_ready=0 for 5 cycles -> s_meta_ready[2] pulses once, m_meta_data stable for 5 cycles, accepted at 6th.
REQ-031 SHALL cover: chan_en=4'b1010, all valid -> grants alternate 1,3,1,3; s_meta_ready[0] and [2] never high.
REQ-032 SHALL cover: net_rst asserted while FULL and m_meta_ready=0 -> next cycle m_meta_valid=0, first post-reset grant to channel 0.
REQ-033 SHALL cover (ROCE_ARB_STATS_EN, CNT_W=4): 20 deliveries from channel 1 -> stat_issued[1]=15, others 0.

Source files
------------

// File: rtl/roce_tx_meta_arb.sv
// Purpose : round-robin merge of N_CHAN role-side tx-meta channels into one registered stream.
// Latency : 1 cycle from input handshake to m_meta_valid; one word per cycle when downstream is ready.
// Backpr. : a channel is accepted only when the output register is empty or drains this cycle.
// Option  : define ROCE_ARB_STATS_EN to add per-channel saturating delivery counters (stat_issued).
module roce_tx_meta_arb #(
  parameter int N_CHAN = 4,
  parameter int META_W = 160,
  parameter int CNT_W  = 32,
  localparam int CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                       net_clk,
  input  logic                       net_rst,
  input  logic [N_CHAN-1:0]          s_meta_valid,
  output logic [N_CHAN-1:0]          s_meta_ready,
  input  logic [N_CHAN*META_W-1:0]   s_meta_data,
  input  logic [N_CHAN-1:0]          chan_en,
  output logic                       m_meta_valid,
  input  logic                       m_meta_ready,
  output logic [META_W-1:0]          m_meta_data,
`ifdef ROCE_ARB_STATS_EN
  output logic [N_CHAN*CNT_W-1:0]    stat_issued,
`endif
  output logic [CHAN_W-1:0]          m_meta_chan
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q;
  logic [META_W-1:0]   data_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [CHAN_W-1:0]   last_grant_q;

  logic [N_CHAN-1:0]   req;
  logic                grant_vld;
  logic [CHAN_W-1:0]   grant_idx;
  logic [META_W-1:0]   grant_dat;
  logic                load;

  // Only enabled channels with a pending word compete; disabled ones are invisible.
  assign req = s_meta_valid & chan_en;

  // Round-robin search starting just after the last winner, wrapping at N_CHAN.
  always_comb begin
    int k;
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int off = 1; off <= N_CHAN; off++) begin
      k = (int'(last_grant_q) + off) % N_CHAN;
      if (!grant_vld && req[k]) begin
        grant_vld = 1'b1;
        grant_idx = CHAN_W'(k);
      end
    end
  end

  // Payload of the winning channel, ready to be captured on load.
  always_comb begin
    grant_dat = s_meta_data[int'(grant_idx)*META_W +: META_W];
  end

  // Accept when the output slot is free or being emptied this cycle; never during reset.
  assign load = (state_q == EMPTY || m_meta_ready) && grant_vld && !net_rst;

  // One-hot accept toward the winning channel only.
  always_comb begin
    s_meta_ready = '0;
    if (load) begin
      s_meta_ready[grant_idx] = 1'b1;
    end
  end

  // Output-slot FSM: captures the granted word and tracks the round-robin pointer.
  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      chan_q       <= '0;
      last_grant_q <= CHAN_W'(N_CHAN - 1);
    end else begin
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_q      <= FULL;
            data_q       <= grant_dat;
            chan_q       <= grant_idx;
            last_grant_q <= grant_idx;
          end
        end
        FULL: begin
          if (load) begin
            data_q       <= grant_dat;
            chan_q       <= grant_idx;
            last_grant_q <= grant_idx;
          end else if (m_meta_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign m_meta_valid = (state_q == FULL);
  assign m_meta_data  = data_q;
  assign m_meta_chan  = chan_q;

`ifdef ROCE_ARB_STATS_EN
  // Per-channel delivered-word counters, saturating at all-ones.
  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_q;

    // Count each downstream handshake attributed to this channel.
    always_ff @(posedge net_clk) begin
      if (net_rst) begin
        cnt_q <= '0;
      end else if (m_meta_valid && m_meta_ready && chan_q == CHAN_W'(gi) && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign stat_issued[gi*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
